// File: rtl/gray_pkg.sv
// Shared Gray-code helpers and direction encodings for the Gray counter family.
package gray_pkg;

    // Widest vector the helpers accept; callers zero-extend and truncate.
    localparam int unsigned GRAY_MAXW = 1024;

    typedef logic [GRAY_MAXW-1:0] gray_vec_t;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    // Zero bits above the caller's width give zero Gray bits, so truncating the
    // result back to the caller's width is exact.
    function automatic gray_vec_t bin2gray(input gray_vec_t v);
        return v ^ (v >> 1);
    endfunction

    // Prefix XOR from the MSB down; zero upper bits leave the low bits unaffected.
    function automatic gray_vec_t gray2bin(input gray_vec_t v);
        gray_vec_t r;
        r = v;
        for (int unsigned k = 1; k < GRAY_MAXW; k++) begin
            r[GRAY_MAXW-1-k] = r[GRAY_MAXW-k] ^ v[GRAY_MAXW-1-k];
        end
        return r;
    endfunction

endpackage

// File: rtl/gray_step.sv
// Combinational next-state unit for the up/down Gray counter.
// Priority: clr > load > en > hold. Wrap or saturate at the range ends.
module gray_step
    import gray_pkg::*;
#(
    parameter int unsigned SIZE     = 128,
    parameter int unsigned SATURATE = 0
) (
    input  logic [SIZE-1:0] b,
    input  logic            clr,
    input  logic            load,
    input  logic [SIZE-1:0] load_bin,
    input  logic            en,
    input  logic            up,
    output logic [SIZE-1:0] b_nxt,
    output logic [SIZE-1:0] g_nxt,
    output logic            wrap_nxt
);

    logic [SIZE:0] inc_w;
    logic [SIZE:0] dec_w;

    // The extra top bit is the carry/borrow out, used only to detect the range end.
    assign inc_w = {1'b0, b} + {{SIZE{1'b0}}, 1'b1};
    assign dec_w = {1'b0, b} - {{SIZE{1'b0}}, 1'b1};

    // Select the next binary value and whether this step wraps.
    always_comb begin
        b_nxt    = b;
        wrap_nxt = 1'b0;
        if (clr) begin
            b_nxt = '0;
        end else if (load) begin
            b_nxt = load_bin;
        end else if (en) begin
            unique case (up)
                DIR_UP: begin
                    if (!inc_w[SIZE]) begin
                        b_nxt = inc_w[SIZE-1:0];
                    end else if (SATURATE == 0) begin
                        b_nxt    = inc_w[SIZE-1:0];
                        wrap_nxt = 1'b1;
                    end
                end
                DIR_DN: begin
                    if (!dec_w[SIZE]) begin
                        b_nxt = dec_w[SIZE-1:0];
                    end else if (SATURATE == 0) begin
                        b_nxt    = dec_w[SIZE-1:0];
                        wrap_nxt = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Gray view of the next binary value.
    always_comb begin
        g_nxt = SIZE'(bin2gray(gray_vec_t'(b_nxt)));
    end

endmodule

// File: rtl/gray_updn_cnt.sv
// Parametrised up/down Gray counter with registered binary mirror and range flags.
// Every output is a flop so downstream synchronisers see one bit change per step.
module gray_updn_cnt
    import gray_pkg::*;
#(
    parameter int unsigned     SIZE      = 128,
    parameter int unsigned     SATURATE  = 0,
    parameter logic [SIZE-1:0] RESET_VAL = '0
) (
    input  logic            clk,
    input  logic            nreset,
    input  logic            clr,
    input  logic            load,
    input  logic [SIZE-1:0] load_bin,
    input  logic            en,
    input  logic            up,
    output logic [SIZE-1:0] q,
    output logic [SIZE-1:0] q_bin,
    output logic            wrap,
    output logic            at_max,
    output logic            at_min
);

    localparam logic [SIZE-1:0] RESET_GRAY = SIZE'(bin2gray(gray_vec_t'(RESET_VAL)));

    logic [SIZE-1:0] b_q, b_d;
    logic [SIZE-1:0] g_q, g_d;
    logic            wrap_q, wrap_d;
    logic            at_max_q, at_max_d;
    logic            at_min_q, at_min_d;

    logic [SIZE-1:0] step_b;
    logic [SIZE-1:0] step_g;
    logic            step_wrap;

    gray_step #(
        .SIZE     (SIZE),
        .SATURATE (SATURATE)
    ) u_step (
        .b        (b_q),
        .clr      (clr),
        .load     (load),
        .load_bin (load_bin),
        .en       (en),
        .up       (up),
        .b_nxt    (step_b),
        .g_nxt    (step_g),
        .wrap_nxt (step_wrap)
    );

    // Flags come from the next binary value so they line up with q on the same edge.
    always_comb begin
        b_d      = step_b;
        g_d      = step_g;
        wrap_d   = step_wrap;
        at_max_d = &step_b;
        at_min_d = ~|step_b;
    end

    // Counter state; reset abandons the count immediately.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            b_q      <= RESET_VAL;
            g_q      <= RESET_GRAY;
            wrap_q   <= 1'b0;
            at_max_q <= &RESET_VAL;
            at_min_q <= ~|RESET_VAL;
        end else begin
            b_q      <= b_d;
            g_q      <= g_d;
            wrap_q   <= wrap_d;
            at_max_q <= at_max_d;
            at_min_q <= at_min_d;
        end
    end

    assign q      = g_q;
    assign q_bin  = b_q;
    assign wrap   = wrap_q;
    assign at_max = at_max_q;
    assign at_min = at_min_q;

endmodule

// File: tb/tb_gray_updn_cnt.sv
// Bench for gray_updn_cnt: five instances (4-bit wrap/saturate, 2-bit wrap,
// 128-bit wrap/saturate) share one stimulus stream and are checked every cycle
// against an arithmetic model, plus hand-computed literal expectations.
module tb_gray_updn_cnt;
    import gray_pkg::*;

    localparam int NI = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         nreset, clr, load, en, up;
    logic [127:0] load_bin;

    logic [3:0]   q0, qb0, q1, qb1;
    logic [1:0]   q2, qb2;
    logic [127:0] q3, qb3, q4, qb4;
    logic         w0, w1, w2, w3, w4;
    logic         mx0, mx1, mx2, mx3, mx4;
    logic         mn0, mn1, mn2, mn3, mn4;

    gray_updn_cnt #(.SIZE(4), .SATURATE(0), .RESET_VAL(4'd5)) u_w4 (
        .clk(clk), .nreset(nreset), .clr(clr), .load(load), .load_bin(load_bin[3:0]),
        .en(en), .up(up), .q(q0), .q_bin(qb0), .wrap(w0), .at_max(mx0), .at_min(mn0));
    gray_updn_cnt #(.SIZE(4), .SATURATE(1), .RESET_VAL(4'd5)) u_s4 (
        .clk(clk), .nreset(nreset), .clr(clr), .load(load), .load_bin(load_bin[3:0]),
        .en(en), .up(up), .q(q1), .q_bin(qb1), .wrap(w1), .at_max(mx1), .at_min(mn1));
    gray_updn_cnt #(.SIZE(2), .SATURATE(0), .RESET_VAL(2'd3)) u_w2 (
        .clk(clk), .nreset(nreset), .clr(clr), .load(load), .load_bin(load_bin[1:0]),
        .en(en), .up(up), .q(q2), .q_bin(qb2), .wrap(w2), .at_max(mx2), .at_min(mn2));
    gray_updn_cnt #(.SIZE(128), .SATURATE(0), .RESET_VAL({128{1'b1}})) u_w128 (
        .clk(clk), .nreset(nreset), .clr(clr), .load(load), .load_bin(load_bin),
        .en(en), .up(up), .q(q3), .q_bin(qb3), .wrap(w3), .at_max(mx3), .at_min(mn3));
    gray_updn_cnt #(.SIZE(128), .SATURATE(1),
                    .RESET_VAL(128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210)) u_s128 (
        .clk(clk), .nreset(nreset), .clr(clr), .load(load), .load_bin(load_bin),
        .en(en), .up(up), .q(q4), .q_bin(qb4), .wrap(w4), .at_max(mx4), .at_min(mn4));

    logic [127:0] aq [NI];
    logic [127:0] ab [NI];
    logic         aw [NI];
    logic         amx[NI];
    logic         amn[NI];
    assign aq[0] = 128'(q0);  assign ab[0] = 128'(qb0);
    assign aq[1] = 128'(q1);  assign ab[1] = 128'(qb1);
    assign aq[2] = 128'(q2);  assign ab[2] = 128'(qb2);
    assign aq[3] = q3;        assign ab[3] = qb3;
    assign aq[4] = q4;        assign ab[4] = qb4;
    assign aw[0] = w0;   assign aw[1] = w1;   assign aw[2] = w2;   assign aw[3] = w3;   assign aw[4] = w4;
    assign amx[0] = mx0; assign amx[1] = mx1; assign amx[2] = mx2; assign amx[3] = mx3; assign amx[4] = mx4;
    assign amn[0] = mn0; assign amn[1] = mn1; assign amn[2] = mn2; assign amn[3] = mn3; assign amn[4] = mn4;

    // Reference model configuration and state.
    int           isize[NI] = '{4, 4, 2, 128, 128};
    bit           isat [NI] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [127:0] irv  [NI];
    logic [127:0] mb   [NI];
    logic         mwrap[NI];
    int           kind [NI];   // 0 other, 1 counting step, 2 saturated hold
    logic [127:0] lastq[NI];

    // Standard 4-bit reflected Gray sequence, written out by hand.
    logic [3:0] gtab[16] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
                             4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000};

    int unsigned checks;
    int unsigned errors;

    function automatic logic [127:0] mask_of(input int s);
        if (s >= 128) return '1;
        return (128'(1) << s) - 128'(1);
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin
            mb[i]    = irv[i];
            mwrap[i] = 1'b0;
            kind[i]  = 0;
        end
    endtask

    task automatic model_step();
        for (int i = 0; i < NI; i++) begin
            logic [127:0] m;
            m        = mask_of(isize[i]);
            mwrap[i] = 1'b0;
            kind[i]  = 0;
            if (!nreset)      mb[i] = irv[i];
            else if (clr)     mb[i] = '0;
            else if (load)    mb[i] = load_bin & m;
            else if (en) begin
                if (up) begin
                    if (mb[i] == m) begin
                        if (isat[i]) kind[i] = 2;
                        else begin mb[i] = '0; mwrap[i] = 1'b1; kind[i] = 1; end
                    end else begin
                        mb[i] = mb[i] + 128'(1); kind[i] = 1;
                    end
                end else begin
                    if (mb[i] == '0) begin
                        if (isat[i]) kind[i] = 2;
                        else begin mb[i] = m; mwrap[i] = 1'b1; kind[i] = 1; end
                    end else begin
                        mb[i] = mb[i] - 128'(1); kind[i] = 1;
                    end
                end
            end
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < NI; i++) begin
            logic [127:0] m;
            m = mask_of(isize[i]);
            chk($sformatf("i%0d_q", i),      aq[i], mb[i] ^ (mb[i] >> 1));
            chk($sformatf("i%0d_qbin", i),   ab[i], mb[i]);
            chk($sformatf("i%0d_wrap", i),   128'(aw[i]), 128'(mwrap[i]));
            chk($sformatf("i%0d_atmax", i),  128'(amx[i]), 128'(mb[i] == m));
            chk($sformatf("i%0d_atmin", i),  128'(amn[i]), 128'(mb[i] == '0));
            chk($sformatf("i%0d_g2b", i),    ab[i], 128'(gray2bin(gray_vec_t'(aq[i]))));
            if (kind[i] == 1)
                chk($sformatf("i%0d_ham1", i), 128'($countones(aq[i] ^ lastq[i])), 128'(1));
            else if (kind[i] == 2)
                chk($sformatf("i%0d_ham0", i), 128'($countones(aq[i] ^ lastq[i])), 128'(0));
            lastq[i] = aq[i];
        end
    endtask

    // One clock: model follows the edge, outputs are compared on the falling edge.
    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        irv[0] = 128'd5;
        irv[1] = 128'd5;
        irv[2] = 128'd3;
        irv[3] = '1;
        irv[4] = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
        nreset = 1'b1; clr = 1'b0; load = 1'b0; en = 1'b0; up = 1'b0; load_bin = '0;

        // Asynchronous reset before any clock edge.
        #2 nreset = 1'b0;
        #1;
        model_reset();
        chk("rst_q",     128'(q0),  128'(4'b0111));
        chk("rst_qbin",  128'(qb0), 128'(5));
        chk("rst_wrap",  128'(w0),  128'(0));
        chk("rst_atmin", 128'(mn0), 128'(0));
        chk("rst_atmax", 128'(mx0), 128'(0));
        compare_all();
        @(negedge clk);
        nreset = 1'b1;

        // Count up from 0 through the wrap; saturating copy sticks at 15.
        clr = 1'b1;
        cycle();
        chk("clr_q",     128'(q0),  128'(0));
        chk("clr_atmin", 128'(mn0), 128'(1));
        clr = 1'b0; en = 1'b1; up = 1'b1;
        for (int k = 1; k <= 18; k++) begin
            cycle();
            chk($sformatf("up_q_%0d", k),    128'(q0), 128'(gtab[k % 16]));
            chk($sformatf("up_wrap_%0d", k), 128'(w0), 128'(k == 16));
            if (k == 16) begin
                chk("wrapstep_atmin", 128'(mn0), 128'(1));
                chk("wrapstep_atmax", 128'(mx0), 128'(0));
            end
            if (k >= 15) begin
                chk($sformatf("sat_qbin_%0d", k),  128'(qb1), 128'(15));
                chk($sformatf("sat_q_%0d", k),     128'(q1),  128'(4'b1000));
                chk($sformatf("sat_wrap_%0d", k),  128'(w1),  128'(0));
                chk($sformatf("sat_atmax_%0d", k), 128'(mx1), 128'(1));
            end
        end
        up = 1'b0;
        cycle();
        chk("sat_down_qbin", 128'(qb1), 128'(14));

        // Down across zero in wrap mode.
        en = 1'b0; load = 1'b1; load_bin = 128'd1;
        cycle();
        chk("dn_load_qbin", 128'(qb0), 128'(1));
        load = 1'b0; en = 1'b1; up = 1'b0;
        cycle();
        chk("dn_qbin_0", 128'(qb0), 128'(0));
        chk("dn_wrap_0", 128'(w0),  128'(0));
        cycle();
        chk("dn_qbin_15", 128'(qb0), 128'(15));
        chk("dn_wrap_15", 128'(w0),  128'(1));
        chk("dn_atmax",   128'(mx0), 128'(1));
        chk("dn_q_15",    128'(q0),  128'(4'b1000));
        cycle();
        chk("dn_qbin_14", 128'(qb0), 128'(14));
        chk("dn_wrap_14", 128'(w0),  128'(0));

        // Priority: clr beats load beats count.
        clr = 1'b1; load = 1'b1; load_bin = 128'd9; en = 1'b1; up = 1'b1;
        cycle();
        chk("pri_clr_qbin", 128'(qb0), 128'(0));
        clr = 1'b0;
        cycle();
        chk("pri_load_qbin", 128'(qb0), 128'(9));
        chk("pri_load_q",    128'(q0),  128'(4'b1101));
        load = 1'b0;
        cycle();
        chk("pri_cnt_qbin", 128'(qb0), 128'(10));
        chk("pri_cnt_q",    128'(q0),  128'(4'b1111));

        // Random soak with occasional asynchronous reset.
        for (int n = 0; n < 3000; n++) begin
            if (!nreset) begin
                nreset = 1'($urandom_range(1));
            end else if ($urandom_range(99) < 2) begin
                nreset = 1'b0;
                #1;
                model_reset();
                compare_all();
            end
            clr  = ($urandom_range(99) < 3);
            load = ($urandom_range(99) < 8);
            en   = ($urandom_range(99) < 85);
            up   = 1'($urandom_range(1));
            case ($urandom_range(2))
                0:       load_bin = {$urandom, $urandom, $urandom, $urandom};
                1:       load_bin = '1 - 128'($urandom_range(3));
                default: load_bin = 128'($urandom_range(3));
            endcase
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gray_updn_cnt.md
Name: gray_updn_cnt

Overview:
- Parametrised up/down Gray-code counter; successor to the fixed-width up-only Gray counter.
- Adds:
  - count enable
  - direction control
  - synchronous clear and parallel load
  - selectable wrap or saturate at the range ends
  - registered binary mirror of the count
  - wrap and end-of-range flags
- Sits at clock-domain boundaries, e.g. FIFO pointers and event counters.
- q is a pure flop output, so downstream synchronisers sample a one-bit-per-step change.

Parameters:
- SIZE, 128, counter width in bits (>=2).
- SATURATE, 0; 0 = wrap modulo 2^SIZE, 1 = hold at the end of range.
- RESET_VAL, 0, binary value loaded on reset (SIZE bits).

Ports:
- clk  input  1  rising-edge clock.
- nreset  input  1  asynchronous active-low reset.
- clr  input  1  synchronous clear to binary 0.
- load  input  1  synchronous parallel load.
- load_bin  input  SIZE  binary value for load.
- en  input  1  count enable.
- up  input  1  direction; 1 = increment, 0 = decrement.
- q  output  SIZE  Gray count, registered.
- q_bin  output  SIZE  binary equivalent of q, registered.
- wrap  output  1  one-cycle pulse: the last step wrapped (max->0 or 0->max).
- at_max  output  1  q_bin == all ones, registered.
- at_min  output  1  q_bin == 0, registered.

Behaviour:
- State: binary register b and Gray register g.
  - q = g, q_bin = b.
  - Invariant g == b ^ (b>>1) after every edge.
- Reset (nreset low, asynchronous):
  - b = RESET_VAL, g = bin2gray(RESET_VAL).
  - wrap = 0.
  - at_max and at_min reflect RESET_VAL.
  - Release is synchronous to clk; the first action happens on the first rising edge with nreset high.
- Per-edge priority: clr > load > en > hold.
  - clr: b <= 0, wrap <= 0.
  - load: b <= load_bin, wrap <= 0.
  - en & up: b <= b+1, modulo 2^SIZE.
    - At b == max: if SATURATE=0, b <= 0 and wrap <= 1; if SATURATE=1, b holds and wrap <= 0.
  - en & ~up: b <= b-1.
    - At b == 0: if SATURATE=0, b <= max and wrap <= 1; if SATURATE=1, b holds and wrap <= 0.
  - otherwise: b holds, wrap <= 0.
- g <= bin2gray(next b); at_max and at_min are computed from next b. All outputs update on the same edge, so latency is 1 cycle from inputs to every output.
- Every counting step (en only) changes exactly one bit of q. Saturated hold changes zero bits. clr and load may change any number of bits.
- Direction may reverse on any cycle; there is no turnaround penalty.
- wrap is never asserted in saturate mode and never asserted by clr or load.
- Reset mid-count: abandons state immediately; wrap is forced to 0 without waiting for the clock.
- Arithmetic is unsigned SIZE-bit; the carry/borrow out is used only for wrap detection.
- No combinational path from inputs to outputs.

Decomposition:
- Package gray_pkg:
  - function bin2gray(v) = v ^ (v>>1)
  - function gray2bin(v), prefix XOR from MSB, for checkers and consumers
  - localparam direction encodings DIR_UP=1, DIR_DN=0
- One natural sub-module: gray_step.
  - Combinational next-state unit: takes b, clr, load, load_bin, en, up.
  - Returns next binary, next Gray and wrap_nxt.
- gray_updn_cnt holds the registers, the reset logic and the flags.

Test Plan:
- Reset, SIZE=4, RESET_VAL=5: hold nreset low mid-clock -> q=4'b0111, q_bin=5, wrap=0, at_min=0, at_max=0, asynchronously, before any clk edge.
- SIZE=4, SATURATE=0, en=1, up=1 from 0 for 17 cycles:
  - q steps 0000, 0001, 0011, 0010, 0110 ... 1000, then 0000.
  - Exactly one bit of q changes per edge.
  - wrap pulses for exactly one cycle on the 15->0 step.
  - At that step at_min=1 and at_max=0.
- Down across zero, SATURATE=0: load_bin=1, then en=1, up=0 -> q_bin 1, 0, 15, 14.
  - wrap=1 only on the 0->15 edge.
  - at_max=1 with q=4'b1000.
- Saturate, SATURATE=1: count up to 15, hold en=1 and up=1 for 3 more cycles -> q_bin stays 15, q stays 1000, wrap stays 0, at_max=1.
  - Then up=0 -> q_bin 14.
- Priority: same edge clr=1, load=1, load_bin=9, en=1 -> q_bin=0.
  - Next edge load=1, en=1 -> q_bin=9, q=4'b1101.
  - Next edge en=1, up=1 -> q_bin=10, q=4'b1111.
- Random soak, SIZE=128 and SIZE=2: random en/up/load/clr/nreset.
  - q == bin2gray(q_bin) on every cycle.
  - Scoreboard matches a reference model.
  - Hamming distance of q is 1 on every counting edge and 0 on every saturated-hold edge.
